// File: rtl/async_fifo_stream_reader.sv
// Read-side adapter for async_fifo: turns the registered rd_en/empty/rd_data pull
// interface into a valid/ready stream through a small credit-controlled buffer.
module async_fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  words_out,
    output logic [CNT_WIDTH-1:0]  starve_cycles
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
    logic [OCC_W-1:0]      r_occ;
    logic                  r_inflight;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_words_out;
    logic [CNT_WIDTH-1:0]  r_starve;

    logic [OCC_W:0]        w_pending;
    logic                  w_credit;
    logic                  w_capture;
    logic                  w_pop;

    // Credits come from registered state only: a same-cycle pop never frees one,
    // which keeps m_ready out of the fifo_rd_en path.
    assign w_pending  = {1'b0, r_occ} + (OCC_W + 1)'(r_inflight);
    assign w_credit   = w_pending < (OCC_W + 1)'(BUF_DEPTH);
    assign fifo_rd_en = !rst && !fifo_empty && w_credit;

    assign w_capture     = r_inflight;
    assign m_valid       = (r_occ != '0);
    assign w_pop         = m_valid && m_ready;
    assign m_data        = r_buf[r_rd_ptr];
    assign words_out     = r_words_out;
    assign starve_cycles = r_starve;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ       <= '0;
            r_inflight  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_words_out <= '0;
            r_starve    <= '0;
        end else begin
            r_inflight <= fifo_rd_en;

            if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_words_out <= r_words_out + 1'b1;
            end

            case ({w_capture, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase

            if (m_ready && !m_valid && (r_starve != '1)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    // NOTE: the buffer is reset because m_data reads straight from it and must
    // be 0 out of reset; it is only BUF_DEPTH words, so the cost is small.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_capture) begin
            r_buf[r_wr_ptr] <= fifo_rd_data;
        end
    end

endmodule

// File: tb/tb_async_fifo_stream_reader.sv
// Bench: behavioural registered-read FIFO in front of the reader, scoreboard
// queue filled at write time, monitor comparing every accepted output word.
module tb_async_fifo_stream_reader;

    localparam int DW = 8;
    localparam int CW = 32;
    localparam int FIFO_CAP = 8;

    logic          clk;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [CW-1:0] words_out;
    logic [CW-1:0] starve_cycles;

    async_fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(4), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .words_out     (words_out),
        .starve_cycles (starve_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural FIFO: empty is immediate, read data registered one cycle after rd_en.
    logic [DW-1:0] mem [1024];
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic fifo_full;
    assign fifo_empty = (wr_cnt == rd_cnt);
    assign fifo_full  = ((wr_cnt - rd_cnt) >= FIFO_CAP);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt       <= wr_cnt;
            fifo_rd_data <= '0;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= mem[rd_cnt % 1024];
            rd_cnt       <= rd_cnt + 1;
        end
    end

    logic [DW-1:0] exp_q [$];

    task automatic wr_word(input logic [DW-1:0] d);
        mem[wr_cnt % 1024] = d;
        wr_cnt = wr_cnt + 1;
        exp_q.push_back(d);
    endtask

    // Issued reads minus accepted words equals occ + inflight.
    int rd_en_cnt;
    int pop_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_cnt <= 0;
            pop_cnt   <= 0;
        end else begin
            if (fifo_rd_en)          rd_en_cnt <= rd_en_cnt + 1;
            if (m_valid && m_ready)  pop_cnt   <= pop_cnt + 1;
        end
    end

    logic          hold_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            check("rd_en_while_empty", {31'b0, fifo_rd_en && fifo_empty}, 32'd0);
            check("credit_bound", {31'b0, (rd_en_cnt - pop_cnt) <= 4}, 32'd1);
            if (hold_prev) begin
                check("valid_held", {31'b0, m_valid}, 32'd1);
                check("data_held", {24'b0, m_data}, {24'b0, data_prev});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_word: got %0h expected none", m_data);
                end else begin
                    check("data", {24'b0, m_data}, {24'b0, exp_q.pop_front()});
                end
            end
            hold_prev = m_valid && !m_ready;
            data_prev = m_data;
        end
    end

    task automatic wait_drain(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int  n;
    int  base;
    int  vcyc;
    bit  rand_done;

    initial begin
        rst     = 1'b1;
        m_ready = 1'b1;
        #1;
        check("rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        check("rst_m_data", {24'b0, m_data}, 32'd0);
        check("rst_words_out", words_out, 32'd0);
        check("rst_starve", starve_cycles, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Starvation then single word.
        repeat (10) @(negedge clk);
        check("starve_idle", starve_cycles, 32'd10);
        wr_word(8'hAB);
        n = 0;
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 32'd2);
        check("starve_at_valid", starve_cycles, 32'd12);
        repeat (5) @(negedge clk);
        check("single_words_out", words_out, 32'd1);
        check("single_rd_en_pulses", rd_en_cnt, 32'd1);
        check("single_pops", pop_cnt, 32'd1);

        // Streaming 0..63 at one word per cycle.
        fork
            for (int i = 0; i < 64; i++) begin
                wr_word(i[7:0]);
                @(negedge clk);
            end
        join_none
        n = 0;
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        vcyc = 0;
        repeat (64) begin
            if (m_valid) vcyc++;
            @(negedge clk);
        end
        check("stream_no_gaps", vcyc, 32'd64);
        wait_drain("stream_drain");
        repeat (3) @(negedge clk);
        check("stream_words_out", words_out, 32'd65);

        // Backpressure: 16 words with m_ready low for 20 cycles.
        m_ready = 1'b0;
        base = rd_en_cnt;
        fork
            for (int i = 0; i < 16; i++) begin
                wr_word(i[7:0]);
                @(negedge clk);
            end
        join_none
        repeat (20) @(negedge clk);
        check("bp_rd_en_pulses", rd_en_cnt - base, 32'd4);
        check("bp_valid", {31'b0, m_valid}, 32'd1);
        check("bp_data", {24'b0, m_data}, 32'd0);
        m_ready = 1'b1;
        wait_drain("bp_drain");
        repeat (3) @(negedge clk);
        check("bp_words_out", words_out, 32'd81);

        // Random m_ready, writer gated by full.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    int g = 0;
                    while (fifo_full && g < 1000) begin
                        @(negedge clk);
                        g++;
                    end
                    wr_word(8'(i * 3 + 1));
                    @(negedge clk);
                end
                wait_drain("rand_drain");
                rand_done = 1'b1;
            end
            while (!rand_done) begin
                @(negedge clk);
                if (!rand_done) m_ready = 1'($urandom_range(0, 1));
            end
        join
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rand_words_out", words_out, 32'd281);

        // Reset with three words buffered.
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_word(8'h77 + 8'(i));
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("pre_rst_valid", {31'b0, m_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("mid_rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        check("mid_rst_words_out", words_out, 32'd0);
        check("mid_rst_starve", starve_cycles, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        wr_word(8'h10);
        wait_drain("post_rst_drain");
        repeat (5) @(negedge clk);
        check("post_rst_words_out", words_out, 32'd1);
        check("post_rst_pops", pop_cnt, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
